// File: rtl/fir_weight_ctrl_if.sv
// Slow-control register bus for the FIR weight controller.
// Carries the write/readback strobes, address, data and the error pulse.
interface fir_weight_ctrl_if;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        err;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  err
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output err
    );
endinterface

// File: rtl/fir_weight_ctrl.sv
// FIR weight controller: shadow weight registers with an atomic, optionally
// sync-aligned commit into the active weights and a post-apply flush window.
module fir_weight_ctrl #(
    parameter int N_CELLS      = 4,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fir_weight_ctrl_if.slave        bus,
    input  logic                    sync,
    output logic [2*N_CELLS*70-1:0] weights_out,
    output logic                    fir_valid,
    output logic                    busy
);

    localparam int          N_FIR = 2 * N_CELLS;
    localparam int          FW    = (N_FIR > 1) ? $clog2(N_FIR) : 1;
    localparam logic [4:0]  NF    = 5'(N_FIR);
    localparam logic [7:0]  CTRL  = 8'hFF;
    localparam logic [7:0]  FLUSH_LD = 8'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [69:0] shadow_q  [N_FIR];
    logic [69:0] shadow_d  [N_FIR];
    logic [69:0] weights_q [N_FIR];
    logic [69:0] weights_d [N_FIR];
    logic [7:0]  cnt_q, cnt_d;
    logic        fir_valid_q, fir_valid_d;
    logic        err_q, err_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic [4:0]    fidx;
    logic [2:0]    widx;
    logic [FW-1:0] fsel;
    logic          is_ctrl;
    logic          addr_ok;
    logic          data_ok;
    logic          ctrl_ok;
    logic          wr_rej;
    logic          commit;
    logic          imm;
    logic          clear;

    assign fidx    = bus.wr_addr[7:3];
    assign widx    = bus.wr_addr[2:0];
    assign fsel    = fidx[FW-1:0];
    assign is_ctrl = (bus.wr_addr == CTRL);
    assign addr_ok = !is_ctrl && (fidx < NF) && (widx <= 3'd4);

    // Shadow stays writable during APPLY/FLUSH; only ARMED freezes it.
    assign data_ok = bus.wr_en && addr_ok && (state_q != ARMED);
    assign ctrl_ok = bus.wr_en && is_ctrl && (state_q == IDLE);
    assign wr_rej  = bus.wr_en && !data_ok && !ctrl_ok;
    assign commit  = ctrl_ok && bus.wr_data[0];
    assign imm     = bus.wr_data[1];
    assign clear   = ctrl_ok && bus.wr_data[2];

    function automatic logic [15:0] word_of(
        input logic [69:0] v,
        input logic [2:0]  k
    );
        logic [15:0] w;
        case (k)
            3'd0:    w = v[15:0];
            3'd1:    w = v[31:16];
            3'd2:    w = v[47:32];
            3'd3:    w = v[63:48];
            3'd4:    w = {10'd0, v[69:64]};
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        shadow_d    = shadow_q;
        weights_d   = weights_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        fir_valid_d = fir_valid_q;
        rd_data_d   = rd_data_q;
        err_d       = wr_rej;

        if (clear) begin
            for (int f = 0; f < N_FIR; f++) begin
                shadow_d[f] = '0;
            end
        end

        if (data_ok) begin
            case (widx)
                3'd0:    shadow_d[fsel][15:0]  = bus.wr_data;
                3'd1:    shadow_d[fsel][31:16] = bus.wr_data;
                3'd2:    shadow_d[fsel][47:32] = bus.wr_data;
                3'd3:    shadow_d[fsel][63:48] = bus.wr_data;
                3'd4:    shadow_d[fsel][69:64] = bus.wr_data[5:0];
                default: ;
            endcase
        end

        if (bus.rd_en) begin
            unique case (1'b1)
                is_ctrl: rd_data_d = {13'd0, state_q, fir_valid_q};
                addr_ok: rd_data_d = word_of(shadow_q[fsel], widx);
                default: begin
                    rd_data_d = '0;
                    err_d     = 1'b1;
                end
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = imm ? APPLY : ARMED;
                end
            end
            ARMED: begin
                if (sync) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // Pre-write shadow is applied; a same-cycle write lands in shadow only.
                weights_d   = shadow_q;
                fir_valid_d = 1'b0;
                cnt_d       = FLUSH_LD;
                state_d     = FLUSH;
            end
            FLUSH: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        fir_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fir_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            for (int f = 0; f < N_FIR; f++) begin
                shadow_q[f]  <= '0;
                weights_q[f] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fir_valid_q <= fir_valid_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            for (int f = 0; f < N_FIR; f++) begin
                shadow_q[f]  <= shadow_d[f];
                weights_q[f] <= weights_d[f];
            end
        end
    end

    for (genvar g = 0; g < N_FIR; g++) begin : g_wout
        assign weights_out[70*g +: 70] = weights_q[g];
    end

    assign fir_valid   = fir_valid_q;
    assign busy        = (state_q != IDLE);
    assign bus.rd_data = rd_data_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_fir_weight_ctrl.sv
// Self-checking bench for fir_weight_ctrl: vector table plus commit,
// sync, reset-abort and clear sequences with a readback scoreboard.
module tb_fir_weight_ctrl;

    localparam int W = 560;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sync = 1'b0;
    logic [W-1:0] weights_out;
    logic         fir_valid;
    logic         busy;

    fir_weight_ctrl_if bus ();

    fir_weight_ctrl #(
        .N_CELLS      (4),
        .FLUSH_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sync        (sync),
        .weights_out (weights_out),
        .fir_valid   (fir_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [15:0]  sb [$];
    logic [15:0]  sb_exp;
    logic [W-1:0] exp_w;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        exp_err;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e);
        bus.rd_en   = 1'b1;
        bus.wr_addr = a;
        sb.push_back(e);
        cyc();
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        chk("idle_timeout", W'(busy), W'(0));
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_w"}, weights_out, W'(0));
        chk({nm, "_fv"}, W'(fir_valid), W'(0));
        chk({nm, "_busy"}, W'(busy), W'(0));
        chk({nm, "_err"}, W'(bus.err), W'(0));
        chk({nm, "_rd"}, W'(bus.rd_data), W'(0));
    endtask

    always @(posedge clk) begin
        if (bus.rd_en && !rst) begin
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", W'(1), W'(0));
            end else begin
                sb_exp = sb.pop_front();
                chk("readback", W'(bus.rd_data), W'(sb_exp));
            end
        end
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        vt[0]  = '{1, 0, 8'h00, 16'h1111, 0, 16'h0000};
        vt[1]  = '{1, 0, 8'h01, 16'h2222, 0, 16'h0000};
        vt[2]  = '{1, 0, 8'h02, 16'h3333, 0, 16'h0000};
        vt[3]  = '{1, 0, 8'h03, 16'h4444, 0, 16'h0000};
        vt[4]  = '{1, 0, 8'h04, 16'hFFFF, 0, 16'h0000};
        vt[5]  = '{0, 1, 8'h00, 16'h0000, 0, 16'h1111};
        vt[6]  = '{0, 1, 8'h01, 16'h0000, 0, 16'h2222};
        vt[7]  = '{0, 1, 8'h02, 16'h0000, 0, 16'h3333};
        vt[8]  = '{0, 1, 8'h03, 16'h0000, 0, 16'h4444};
        vt[9]  = '{0, 1, 8'h04, 16'h0000, 0, 16'h003F};
        vt[10] = '{1, 0, 8'h05, 16'hBEEF, 1, 16'h0000};
        vt[11] = '{1, 0, 8'h40, 16'hBEEF, 1, 16'h0000};
        vt[12] = '{0, 1, 8'h07, 16'h0000, 1, 16'h0000};
        vt[13] = '{0, 1, 8'h3C, 16'h0000, 0, 16'h0000};
        vt[14] = '{0, 1, 8'hFF, 16'h0000, 0, 16'h0000};

        cyc();
        cyc();
        reset_checks("reset");
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 15; i++) begin
            bus.wr_en   = vt[i].we;
            bus.rd_en   = vt[i].re;
            bus.wr_addr = vt[i].addr;
            bus.wr_data = vt[i].data;
            if (vt[i].re) sb.push_back(vt[i].exp_rd);
            cyc();
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
            chk($sformatf("vec%0d_err", i), W'(bus.err), W'(vt[i].exp_err));
        end
        chk("idle_w_unchanged", weights_out, W'(0));
        chk("idle_fv_low", W'(fir_valid), W'(0));
        chk("idle_busy", W'(busy), W'(0));

        exp_w = '0;
        exp_w[69:0] = 70'h3F_4444_3333_2222_1111;
        wr(8'hFF, 16'h0003);
        chk("imm_t1_busy", W'(busy), W'(1));
        chk("imm_t1_w", weights_out, W'(0));
        cyc();
        chk("imm_t2_w", weights_out, exp_w);
        chk("imm_t2_fv", W'(fir_valid), W'(0));
        for (int i = 3; i <= 11; i++) begin
            cyc();
            chk($sformatf("imm_t%0d_fv", i), W'(fir_valid), W'(i >= 10));
            chk($sformatf("imm_t%0d_busy", i), W'(busy), W'(i <= 10));
        end
        rd(8'hFF, 16'h0001);

        wr(8'h08, 16'hABCD);
        chk("idle_wr_no_apply", weights_out, exp_w);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'hFF;
        bus.wr_data = 16'h0001;
        sync        = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        sync      = 1'b0;
        chk("armed_busy", W'(busy), W'(1));
        rd(8'hFF, 16'h0003);
        wr(8'h08, 16'h1234);
        chk("armed_wr_err", W'(bus.err), W'(1));
        wr(8'hFF, 16'h0003);
        chk("armed_ctrl_err", W'(bus.err), W'(1));
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("armed_hold_w", weights_out, exp_w);
        end
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("sync_s1_w", weights_out, exp_w);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'h10;
        bus.wr_data = 16'h5555;
        cyc();
        bus.wr_en = 1'b0;
        exp_w[70 +: 16] = 16'hABCD;
        chk("sync_s2_w", weights_out, exp_w);
        chk("sync_s2_fv", W'(fir_valid), W'(0));
        wait_idle();
        rd(8'h08, 16'hABCD);
        rd(8'h10, 16'h5555);
        chk("apply_wr_shadow_only", weights_out, exp_w);

        wr(8'h00, 16'h0F0F);
        wr(8'hFF, 16'h0001);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        reset_checks("rst_armed");
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        cyc();
        chk("rst_armed_nosync_w", weights_out, W'(0));
        chk("rst_armed_nosync_busy", W'(busy), W'(0));

        wr(8'h09, 16'h7777);
        wr(8'hFF, 16'h0003);
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        reset_checks("rst_flush");
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        cyc();
        chk("rst_flush_nosync_w", weights_out, W'(0));
        rd(8'h09, 16'h0000);

        wr(8'h3C, 16'h002A);
        wr(8'h00, 16'h9999);
        wr(8'hFF, 16'h0003);
        wait_idle();
        exp_w = '0;
        exp_w[15:0] = 16'h9999;
        exp_w[70*7+64 +: 6] = 6'h2A;
        chk("pre_clear_w", weights_out, exp_w);
        wr(8'hFF, 16'h0007);
        wait_idle();
        chk("clear_commit_w", weights_out, W'(0));
        chk("clear_commit_fv", W'(fir_valid), W'(1));
        rd(8'h3C, 16'h0000);
        rd(8'hFF, 16'h0001);

        cyc();
        chk("sb_empty", W'(sb.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
